// File: rtl/sky130_ef_sc_hd__pwrseq_ctrl.sv
// Power-domain sequencer: staged header-switch ramp with isolation control,
// answering a 4-phase request/acknowledge handshake from the always-on side.
module sky130_ef_sc_hd__pwrseq_ctrl #(
   parameter int NSTAGES = 4,
   parameter int DLY_W   = 8
) (
   input  logic               CLK,
   input  logic               RESET_B,
   input  logic               PWR_REQ,
   input  logic [DLY_W-1:0]   DLY,
   output logic [NSTAGES-1:0] SW_EN,
   output logic               ISO_B,
   output logic               PWR_ACK,
   output logic               BUSY
);

   typedef enum logic [1:0] {
      ST_OFF     = 2'd0,
      ST_RAMP_UP = 2'd1,
      ST_ON      = 2'd2,
      ST_RAMP_DN = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [DLY_W-1:0]   cnt_q, cnt_d;
   logic [DLY_W-1:0]   dly_q, dly_d;
   logic [NSTAGES-1:0] sw_d;
   logic               iso_d, ack_d, busy_d;

   // All outputs are registered copies of the next-state values.
   always_ff @(posedge CLK or negedge RESET_B) begin
      if (!RESET_B) begin
         state_q <= ST_OFF;
         cnt_q   <= '0;
         dly_q   <= '0;
         SW_EN   <= '0;
         ISO_B   <= 1'b0;
         PWR_ACK <= 1'b0;
         BUSY    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dly_q   <= dly_d;
         SW_EN   <= sw_d;
         ISO_B   <= iso_d;
         PWR_ACK <= ack_d;
         BUSY    <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dly_d   = dly_q;
      sw_d    = SW_EN;
      iso_d   = ISO_B;
      ack_d   = PWR_ACK;

      unique case (state_q)
         ST_OFF: begin
            if (PWR_REQ) begin
               state_d = ST_RAMP_UP;
               sw_d    = NSTAGES'(1);
               dly_d   = DLY;
               cnt_d   = DLY;
            end
         end
         // ISO_B already high marks the single cycle before acknowledging.
         ST_RAMP_UP: begin
            if (ISO_B) begin
               state_d = ST_ON;
               ack_d   = 1'b1;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - DLY_W'(1);
            end else if (SW_EN[NSTAGES-1]) begin
               iso_d = 1'b1;
            end else begin
               sw_d  = (SW_EN << 1) | NSTAGES'(1);
               cnt_d = dly_q;
            end
         end
         ST_ON: begin
            if (!PWR_REQ) begin
               state_d = ST_RAMP_DN;
               iso_d   = 1'b0;
               dly_d   = DLY;
               cnt_d   = DLY;
            end
         end
         ST_RAMP_DN: begin
            if (SW_EN == '0) begin
               state_d = ST_OFF;
               ack_d   = 1'b0;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - DLY_W'(1);
            end else begin
               sw_d  = SW_EN >> 1;
               cnt_d = dly_q;
            end
         end
         default: state_d = ST_OFF;
      endcase

      busy_d = (state_d == ST_RAMP_UP) || (state_d == ST_RAMP_DN);
   end

endmodule

// File: tb/tb_sky130_ef_sc_hd__pwrseq_ctrl.sv
// Randomized bench for the power sequencer: two instances (4 stages and 1 stage)
// checked every cycle against an elapsed-time model of the ramp schedule.
module tb_sky130_ef_sc_hd__pwrseq_ctrl;

   logic       clk = 1'b0;
   logic       resetB = 1'b0;
   logic       pwrReq = 1'b0;
   logic [7:0] dlyIn = 8'd0;
   logic       checkEn = 1'b1;

   logic [3:0] swEn4;
   logic       isoB4, ack4, busy4;
   logic [0:0] swEn1;
   logic       isoB1, ack1, busy1;

   int totalCount = 0;
   int badCount = 0;

   always #5 clk = ~clk;

   sky130_ef_sc_hd__pwrseq_ctrl #(.NSTAGES(4), .DLY_W(8)) dut4 (
      .CLK(clk), .RESET_B(resetB), .PWR_REQ(pwrReq), .DLY(dlyIn),
      .SW_EN(swEn4), .ISO_B(isoB4), .PWR_ACK(ack4), .BUSY(busy4)
   );

   sky130_ef_sc_hd__pwrseq_ctrl #(.NSTAGES(1), .DLY_W(8)) dut1 (
      .CLK(clk), .RESET_B(resetB), .PWR_REQ(pwrReq), .DLY(dlyIn),
      .SW_EN(swEn1), .ISO_B(isoB1), .PWR_ACK(ack1), .BUSY(busy1)
   );

   // Reference model: mode plus edges elapsed since the request was sampled.
   localparam int M_OFF = 0, M_UP = 1, M_ON = 2, M_DN = 3;
   int nStages[2] = '{4, 1};
   int mMode[2];
   int mT[2];
   int mD[2];

   always @(posedge clk or negedge resetB) begin
      for (int i = 0; i < 2; i++) begin
         if (!resetB) begin
            mMode[i] = M_OFF;
            mT[i] = 0;
            mD[i] = 0;
         end else begin
            case (mMode[i])
               M_OFF: if (pwrReq) begin mMode[i] = M_UP; mT[i] = 0; mD[i] = int'(dlyIn); end
               M_ON:  if (!pwrReq) begin mMode[i] = M_DN; mT[i] = 0; mD[i] = int'(dlyIn); end
               M_UP: begin
                  mT[i]++;
                  if (mT[i] == nStages[i] * (mD[i] + 1) + 1) mMode[i] = M_ON;
               end
               default: begin
                  mT[i]++;
                  if (mT[i] == nStages[i] * (mD[i] + 1) + 1) mMode[i] = M_OFF;
               end
            endcase
         end
      end
   end

   // Derive expected outputs from the schedule: stage k at k*(D+1), iso at N*(D+1).
   task automatic computeExpect(input int i, output int sw, output int iso,
                                output int ack, output int busy);
      int n, k, step;
      n = nStages[i];
      step = mD[i] + 1;
      sw = 0; iso = 0; ack = 0; busy = 0;
      case (mMode[i])
         M_UP: begin
            k = mT[i] / step + 1;
            if (k > n) k = n;
            sw = (1 << k) - 1;
            iso = (mT[i] >= n * step) ? 1 : 0;
            busy = 1;
         end
         M_ON: begin
            sw = (1 << n) - 1;
            iso = 1;
            ack = 1;
         end
         M_DN: begin
            k = mT[i] / step;
            if (k > n) k = n;
            sw = (1 << (n - k)) - 1;
            ack = 1;
            busy = 1;
         end
         default: ;
      endcase
   endtask

   task automatic checkOutput(input string tag, input int observed, input int expected);
      totalCount++;
      if (observed !== expected) begin
         badCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Per-cycle comparison, sampled on the falling edge away from state changes.
   always @(negedge clk) begin
      int sw, iso, ack, busy;
      if (checkEn) begin
         computeExpect(0, sw, iso, ack, busy);
         checkOutput("n4_sw_en", int'(swEn4), sw);
         checkOutput("n4_iso_b", int'(isoB4), iso);
         checkOutput("n4_ack", int'(ack4), ack);
         checkOutput("n4_busy", int'(busy4), busy);
         computeExpect(1, sw, iso, ack, busy);
         checkOutput("n1_sw_en", int'(swEn1), sw);
         checkOutput("n1_iso_b", int'(isoB1), iso);
         checkOutput("n1_ack", int'(ack1), ack);
         checkOutput("n1_busy", int'(busy1), busy);
      end
   end

   // Drive inputs just after a falling edge and hold them for a number of cycles.
   task automatic applyStimulus(input logic req, input logic [7:0] dly, input int cycles);
      pwrReq = req;
      dlyIn = dly;
      repeat (cycles) @(negedge clk);
   endtask

   initial begin
      $display("[TB] starting power sequencer bench");
      repeat (2) @(negedge clk);
      checkOutput("reset_sw_en", int'(swEn4), 0);
      checkOutput("reset_iso_b", int'(isoB4), 0);
      resetB = 1'b1;
      @(negedge clk);

      // Directed: D=2 up and down, then D=0 up and down.
      applyStimulus(1'b1, 8'd2, 16);
      applyStimulus(1'b0, 8'd2, 16);
      applyStimulus(1'b1, 8'd0, 8);
      applyStimulus(1'b0, 8'd0, 8);

      // Request dropped mid-ramp with a new DLY: old ramp completes, then full D=7 down.
      applyStimulus(1'b1, 8'd2, 5);
      applyStimulus(1'b0, 8'd7, 45);

      // Asynchronous reset in the middle of a ramp-up.
      applyStimulus(1'b1, 8'd2, 7);
      #2;
      resetB = 1'b0;
      #1;
      checkOutput("async_sw_en", int'(swEn4), 0);
      checkOutput("async_iso_b", int'(isoB4), 0);
      checkOutput("async_ack", int'(ack4), 0);
      checkOutput("async_busy", int'(busy4), 0);
      @(negedge clk);
      resetB = 1'b1;
      applyStimulus(1'b1, 8'd1, 12);
      applyStimulus(1'b0, 8'd1, 12);

      // Longest delay: one-stage instance must take 256 cycles per step.
      applyStimulus(1'b1, 8'd255, 1030);
      applyStimulus(1'b0, 8'd255, 1030);

      // Random requests, with DLY also churning while ramps run.
      for (int iter = 0; iter < 60; iter++) begin
         logic req;
         int hold;
         req = 1'($urandom_range(0, 1));
         hold = $urandom_range(1, 25);
         for (int c = 0; c < hold; c++)
            applyStimulus(req, 8'($urandom_range(0, 3)), 1);
      end

      applyStimulus(1'b0, 8'd0, 30);
      checkEn = 1'b0;
      $display("test done: total=%0d bad=%0d", totalCount, badCount);
      $finish;
   end

endmodule
